// File: rtl/sparse_pair_matcher.sv
// Index-merge stage: intersects two index-sorted sparse streams and emits one
// operand pair per matching index, then a done pulse with the pair count.
module sparse_pair_matcher #(
    parameter int IDX_W  = 8,
    parameter int DATA_W = 16,
    parameter int CNT_W  = IDX_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [IDX_W-1:0]  a_idx,
    input  logic [DATA_W-1:0] a_data,
    input  logic              a_last,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [IDX_W-1:0]  b_idx,
    input  logic [DATA_W-1:0] b_data,
    input  logic              b_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [IDX_W-1:0]  out_idx,
    output logic              done,
    output logic [CNT_W-1:0]  match_count,
    output logic              order_err
);

    typedef enum logic [1:0] {S_MERGE, S_DRAIN_A, S_DRAIN_B, S_DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t              r_state;
    state_t              w_state_next;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_a;
    logic [DATA_W-1:0]   r_out_b;
    logic [IDX_W-1:0]    r_out_idx;
    logic                r_done;
    logic [CNT_W-1:0]    r_match_count;
    logic [CNT_W-1:0]    r_count;
    logic                r_order_err;
    logic [IDX_W-1:0]    r_prev_a;
    logic [IDX_W-1:0]    r_prev_b;
    logic                r_first_a;
    logic                r_first_b;

    logic                w_slot_free;
    logic                w_a_ready;
    logic                w_b_ready;
    logic                w_load;
    logic                w_pop_a;
    logic                w_pop_b;
    logic                w_finish;

    assign w_slot_free = !r_out_valid || out_ready;
    assign w_pop_a     = a_valid && w_a_ready;
    assign w_pop_b     = b_valid && w_b_ready;
    assign w_finish    = (r_state == S_DONE) && !r_out_valid;

    always_comb begin
        w_a_ready    = 1'b0;
        w_b_ready    = 1'b0;
        w_load       = 1'b0;
        w_state_next = r_state;
        case (r_state)
            S_MERGE: begin
                if (a_valid && b_valid && w_slot_free) begin
                    if (a_idx == b_idx) begin
                        w_a_ready = 1'b1;
                        w_b_ready = 1'b1;
                        w_load    = 1'b1;
                    end else if (a_idx < b_idx) begin
                        w_a_ready = 1'b1;
                    end else begin
                        w_b_ready = 1'b1;
                    end
                end
                if (w_a_ready && a_last && w_b_ready && b_last)
                    w_state_next = S_DONE;
                else if (w_a_ready && a_last)
                    w_state_next = S_DRAIN_B;
                else if (w_b_ready && b_last)
                    w_state_next = S_DRAIN_A;
            end
            S_DRAIN_A: begin
                w_a_ready = 1'b1;
                if (a_valid && a_last)
                    w_state_next = S_DONE;
            end
            S_DRAIN_B: begin
                w_b_ready = 1'b1;
                if (b_valid && b_last)
                    w_state_next = S_DONE;
            end
            S_DONE: begin
                if (!r_out_valid)
                    w_state_next = S_MERGE;
            end
            default: w_state_next = S_MERGE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_MERGE;
            r_out_valid   <= 1'b0;
            r_out_a       <= '0;
            r_out_b       <= '0;
            r_out_idx     <= '0;
            r_done        <= 1'b0;
            r_match_count <= '0;
            r_count       <= '0;
            r_order_err   <= 1'b0;
            r_prev_a      <= '0;
            r_prev_b      <= '0;
            r_first_a     <= 1'b1;
            r_first_b     <= 1'b1;
        end else begin
            r_state <= w_state_next;

            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_a     <= a_data;
                r_out_b     <= b_data;
                r_out_idx   <= a_idx;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            r_done <= w_finish;
            if (w_finish) begin
                r_match_count <= r_count;
                r_count       <= '0;
            end else if (w_load && r_count != CNT_MAX) begin
                r_count <= r_count + CNT_ONE;
            end

            // A popped last entry re-arms the first flag so the next vector starts fresh
            if (w_pop_a) begin
                if (!r_first_a && a_idx <= r_prev_a)
                    r_order_err <= 1'b1;
                r_prev_a  <= a_idx;
                r_first_a <= a_last;
            end
            if (w_pop_b) begin
                if (!r_first_b && b_idx <= r_prev_b)
                    r_order_err <= 1'b1;
                r_prev_b  <= b_idx;
                r_first_b <= b_last;
            end
        end
    end

    assign a_ready     = w_a_ready;
    assign b_ready     = w_b_ready;
    assign out_valid   = r_out_valid;
    assign out_a       = r_out_a;
    assign out_b       = r_out_b;
    assign out_idx     = r_out_idx;
    assign done        = r_done;
    assign match_count = r_match_count;
    assign order_err   = r_order_err;

endmodule

// File: tb/tb_sparse_pair_matcher.sv
// Bench for sparse_pair_matcher: directed and random vector pairs checked against
// a set-intersection reference model, plus order-error and async-reset scenarios.
module tb_sparse_pair_matcher;

    localparam int IDX_W  = 8;
    localparam int DATA_W = 16;
    localparam int CNT_W  = IDX_W + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              a_valid, a_ready, a_last;
    logic [IDX_W-1:0]  a_idx;
    logic [DATA_W-1:0] a_data;
    logic              b_valid, b_ready, b_last;
    logic [IDX_W-1:0]  b_idx;
    logic [DATA_W-1:0] b_data;
    logic              out_valid, out_ready;
    logic [DATA_W-1:0] out_a, out_b;
    logic [IDX_W-1:0]  out_idx;
    logic              done;
    logic [CNT_W-1:0]  match_count;
    logic              order_err;

    sparse_pair_matcher #(.IDX_W(IDX_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_idx(a_idx), .a_data(a_data), .a_last(a_last),
        .b_valid(b_valid), .b_ready(b_ready), .b_idx(b_idx), .b_data(b_data), .b_last(b_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_idx(out_idx),
        .done(done), .match_count(match_count), .order_err(order_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int gap_max = 0;

    logic [IDX_W-1:0]  qa_idx[$];
    logic [DATA_W-1:0] qa_dat[$];
    logic [IDX_W-1:0]  qb_idx[$];
    logic [DATA_W-1:0] qb_dat[$];
    logic [DATA_W-1:0] exp_a[$];
    logic [DATA_W-1:0] exp_b[$];
    logic [IDX_W-1:0]  exp_i[$];
    int exp_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: for strictly increasing streams, the pairs are the index intersection in order
    function automatic void build_expected();
        exp_a.delete(); exp_b.delete(); exp_i.delete();
        foreach (qa_idx[i])
            foreach (qb_idx[j])
                if (qa_idx[i] == qb_idx[j]) begin
                    exp_a.push_back(qa_dat[i]);
                    exp_b.push_back(qb_dat[j]);
                    exp_i.push_back(qa_idx[i]);
                end
        exp_cnt = exp_i.size();
    endfunction

    function automatic void gen_random();
        int n;
        int idx;
        qa_idx.delete(); qa_dat.delete(); qb_idx.delete(); qb_dat.delete();
        n = $urandom_range(1, 10);
        idx = $urandom_range(0, 3);
        for (int i = 0; i < n; i++) begin
            qa_idx.push_back(IDX_W'(idx));
            qa_dat.push_back(DATA_W'($urandom));
            idx += $urandom_range(1, 3);
        end
        n = $urandom_range(1, 10);
        idx = $urandom_range(0, 3);
        for (int i = 0; i < n; i++) begin
            qb_idx.push_back(IDX_W'(idx));
            qb_dat.push_back(DATA_W'($urandom));
            idx += $urandom_range(1, 3);
        end
    endfunction

    task automatic drive_a();
        int t;
        foreach (qa_idx[i]) begin
            a_valid = 1'b0;
            repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
            a_valid = 1'b1;
            a_idx   = qa_idx[i];
            a_data  = qa_dat[i];
            a_last  = (i == qa_idx.size() - 1);
            t = 0;
            forever begin
                @(negedge clk);
                if (a_ready) break;
                t++;
                if (t > 2000) begin
                    check("a_accept_timeout", 1, 0);
                    a_valid = 1'b0;
                    return;
                end
            end
            @(posedge clk); #1;
        end
        a_valid = 1'b0;
        a_last  = 1'b0;
    endtask

    task automatic drive_b();
        int t;
        foreach (qb_idx[i]) begin
            b_valid = 1'b0;
            repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
            b_valid = 1'b1;
            b_idx   = qb_idx[i];
            b_data  = qb_dat[i];
            b_last  = (i == qb_idx.size() - 1);
            t = 0;
            forever begin
                @(negedge clk);
                if (b_ready) break;
                t++;
                if (t > 2000) begin
                    check("b_accept_timeout", 1, 0);
                    b_valid = 1'b0;
                    return;
                end
            end
            @(posedge clk); #1;
        end
        b_valid = 1'b0;
        b_last  = 1'b0;
    endtask

    // mode 0: out_ready always 1, 1: toggling, 2: random
    task automatic monitor(input int mode);
        int t = 0;
        logic stall_prev = 1'b0;
        logic [DATA_W-1:0] pa, pb;
        logic [IDX_W-1:0]  pi;
        forever begin
            @(negedge clk);
            if (stall_prev) begin
                check("stall_valid", out_valid, 1);
                check("stall_out_a", out_a, pa);
                check("stall_out_b", out_b, pb);
                check("stall_out_idx", out_idx, pi);
            end
            if (out_valid && out_ready) begin
                if (exp_i.size() == 0) begin
                    check("unexpected_pair_idx", out_idx, 32'hFFFF_FFFF);
                end else begin
                    check("out_a", out_a, exp_a.pop_front());
                    check("out_b", out_b, exp_b.pop_front());
                    check("out_idx", out_idx, exp_i.pop_front());
                end
            end
            stall_prev = out_valid && !out_ready;
            pa = out_a; pb = out_b; pi = out_idx;
            if (done) begin
                check("match_count", match_count, exp_cnt);
                check("pairs_missing", exp_i.size(), 0);
                @(negedge clk);
                check("done_one_cycle", done, 0);
                return;
            end
            t++;
            if (t > 3000) begin
                check("done_timeout", 1, 0);
                return;
            end
            @(posedge clk); #1;
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    endtask

    task automatic run_pair(input int mode);
        out_ready = 1'b1;
        fork
            drive_a();
            drive_b();
            monitor(mode);
        join
        @(posedge clk); #1;
    endtask

    task automatic push_a(input int idx, input int dat);
        qa_idx.push_back(IDX_W'(idx)); qa_dat.push_back(DATA_W'(dat));
    endtask
    task automatic push_b(input int idx, input int dat);
        qb_idx.push_back(IDX_W'(idx)); qb_dat.push_back(DATA_W'(dat));
    endtask
    function automatic void clear_q();
        qa_idx.delete(); qa_dat.delete(); qb_idx.delete(); qb_dat.delete();
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin
        reset = 1'b1;
        a_valid = 0; a_idx = 0; a_data = 0; a_last = 0;
        b_valid = 0; b_idx = 0; b_data = 0; b_last = 0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_done", done, 0);
        check("rst_match_count", match_count, 0);
        check("rst_order_err", order_err, 0);
        check("rst_out_a", out_a, 0);
        check("rst_out_idx", out_idx, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Match then end
        clear_q();
        push_a(1, 16'h3C00); push_a(4, 16'h4000);
        push_b(2, 16'h4200); push_b(4, 16'h4400);
        build_expected();
        run_pair(0);
        check("match_end_order_err", order_err, 0);

        // Drain path
        clear_q();
        push_a(0, 16'h1001); push_a(1, 16'h1002);
        push_b(0, 16'h2001); push_b(5, 16'h2005); push_b(7, 16'h2007);
        build_expected();
        run_pair(0);

        // Backpressure with full overlap
        clear_q();
        for (int i = 0; i < 8; i++) begin
            push_a(i, 16'hA000 + i);
            push_b(i, 16'hB000 + i);
        end
        build_expected();
        run_pair(1);

        // No overlap
        clear_q();
        push_a(1, 16'h0011); push_a(3, 16'h0033); push_a(5, 16'h0055);
        push_b(2, 16'h0022); push_b(4, 16'h0044); push_b(6, 16'h0066);
        build_expected();
        run_pair(0);

        // Random vector pairs with input gaps and output backpressure
        gap_max = 2;
        for (int r = 0; r < 12; r++) begin
            gen_random();
            build_expected();
            run_pair(r % 3);
        end
        check("random_order_err", order_err, 0);
        gap_max = 0;

        // Order error: B pops 2 (last), A drains 3 then 2; nothing matches
        clear_q();
        push_a(3, 16'h0303); push_a(2, 16'h0202);
        push_b(2, 16'h0A02);
        exp_a.delete(); exp_b.delete(); exp_i.delete();
        exp_cnt = 0;
        run_pair(0);
        check("order_err_set", order_err, 1);
        gen_random();
        build_expected();
        run_pair(2);
        check("order_err_sticky", order_err, 1);

        // Reset mid-vector with a pair held in the slot
        out_ready = 1'b0;
        a_valid = 1; a_idx = 0; a_data = 16'h1111; a_last = 0;
        b_valid = 1; b_idx = 0; b_data = 16'h2222; b_last = 0;
        @(posedge clk); #1;
        a_valid = 0; b_valid = 0;
        check("held_out_valid", out_valid, 1);
        check("held_out_a", out_a, 16'h1111);
        #2;
        reset = 1'b1;
        #1;
        check("async_out_valid", out_valid, 0);
        check("async_out_a", out_a, 0);
        check("async_out_b", out_b, 0);
        check("async_out_idx", out_idx, 0);
        check("async_done", done, 0);
        check("async_match_count", match_count, 0);
        check("async_order_err", order_err, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        clear_q();
        push_a(0, 16'h5000); push_a(3, 16'h5003); push_a(9, 16'h5009);
        push_b(3, 16'h6003); push_b(9, 16'h6009);
        build_expected();
        run_pair(2);
        check("post_reset_order_err", order_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
